// File: rtl/pl_master_pkg.sv
// rtl/pl_master_pkg.sv - shared op/state enums and preload address layout
package pl_master_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'd0,
      OP_READ   = 2'd1,
      OP_CHECK  = 2'd2,
      OP_STATUS = 2'd3
   } pl_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CHECK,
      ST_STATUS,
      ST_DRAIN,
      ST_DONE
   } pl_state_e;

   localparam int PL_ADDR_W  = 32;
   localparam int PL_ID_W    = 20;
   localparam int PL_GAP_W   = 2;
   localparam int PL_WADDR_W = 10;

   // PL_ADDR = {id, 2'b00, word address}
   function automatic logic [PL_ADDR_W-1:0] make_pl_addr(input logic [PL_ID_W-1:0]    id,
                                                         input logic [PL_WADDR_W-1:0] waddr);
      return {id, PL_GAP_W'(0), waddr};
   endfunction

endpackage

// File: rtl/pl_beat_gen.sv
// rtl/pl_beat_gen.sv - burst beat counter and wrapping word-address incrementer
module pl_beat_gen
   import pl_master_pkg::*;
#(
   parameter int WADDR_W = 10
) (
   input  logic               PL_CLK_i,
   input  logic               RESET_ni,
   input  logic               load,
   input  logic               step,
   input  logic [WADDR_W-1:0] start_addr,
   input  logic [WADDR_W-1:0] len,
   output logic [WADDR_W-1:0] addr,
   output logic               last
);

   localparam logic [WADDR_W-1:0] ONE = WADDR_W'(1);

   logic [WADDR_W-1:0] cnt;

   // cnt holds beats remaining minus one; address wraps naturally at 2^WADDR_W
   always_ff @(posedge PL_CLK_i or negedge RESET_ni) begin
      if (!RESET_ni) begin
         addr <= '0;
         cnt  <= '0;
      end else if (load) begin
         addr <= start_addr;
         cnt  <= len;
      end else if (step) begin
         addr <= addr + ONE;
         cnt  <= cnt - ONE;
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/pl_preload_master.sv
// rtl/pl_preload_master.sv - preload bus master; PL_MASTER_ERR_EN enables STATUS error flag
module pl_preload_master
   import pl_master_pkg::*;
#(
   parameter int DATA_W  = 18,
   parameter int WADDR_W = 10
) (
   input  logic                 PL_CLK_i,
   input  logic                 RESET_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [1:0]           cmd_op_i,
   input  logic [PL_ID_W-1:0]   cmd_id_i,
   input  logic [WADDR_W-1:0]   cmd_addr_i,
   input  logic [WADDR_W-1:0]   cmd_len_i,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [DATA_W-1:0]    wr_data_i,
   output logic                 rd_valid_o,
   output logic [DATA_W-1:0]    rd_data_o,
   output logic                 PL_ENA_o,
   output logic                 PL_WEN_o,
   output logic                 PL_REN_o,
   output logic                 PL_INIT_o,
   output logic [PL_ADDR_W-1:0] PL_ADDR_o,
   output logic [DATA_W-1:0]    PL_DATA_o,
   input  logic [DATA_W-1:0]    PL_DATA_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   pl_state_e            state;
   logic [PL_ID_W-1:0]   id_q;
   logic                 rd_pend;
   logic                 accept;
   logic                 step;
   logic [WADDR_W-1:0]   len_sel;
   logic [WADDR_W-1:0]   beat_addr;
   logic                 beat_last;
   logic [PL_ADDR_W-1:0] beat_pl_addr;

   assign accept       = cmd_valid_i && (state == ST_IDLE);
   assign len_sel      = (cmd_op_i == OP_STATUS) ? '0 : cmd_len_i;
   assign step         = (((state == ST_WRITE) || (state == ST_CHECK)) && wr_valid_i)
                         || (state == ST_READ);
   assign beat_pl_addr = make_pl_addr(id_q, PL_WADDR_W'(beat_addr));

   assign cmd_ready_o  = RESET_ni && (state == ST_IDLE);
   assign wr_ready_o   = (state == ST_WRITE) || (state == ST_CHECK);
   assign busy_o       = (state != ST_IDLE);

   pl_beat_gen #(.WADDR_W(WADDR_W)) u_beat_gen (
      .PL_CLK_i   (PL_CLK_i),
      .RESET_ni   (RESET_ni),
      .load       (accept),
      .step       (step),
      .start_addr (cmd_addr_i),
      .len        (len_sel),
      .addr       (beat_addr),
      .last       (beat_last)
   );

   // Command FSM; bus strobes default low so each beat lasts exactly one cycle
   always_ff @(posedge PL_CLK_i or negedge RESET_ni) begin
      if (!RESET_ni) begin
         state      <= ST_IDLE;
         id_q       <= '0;
         PL_ENA_o   <= 1'b0;
         PL_WEN_o   <= 1'b0;
         PL_REN_o   <= 1'b0;
         PL_INIT_o  <= 1'b0;
         PL_ADDR_o  <= '0;
         PL_DATA_o  <= '0;
         rd_pend    <= 1'b0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         done_o     <= 1'b0;
      end else begin
         PL_ENA_o   <= 1'b0;
         PL_WEN_o   <= 1'b0;
         PL_REN_o   <= 1'b0;
         PL_INIT_o  <= 1'b0;
         PL_ADDR_o  <= '0;
         PL_DATA_o  <= '0;
         rd_pend    <= 1'b0;
         done_o     <= 1'b0;
         // read data is sampled while its beat is on the bus
         rd_valid_o <= rd_pend;
         rd_data_o  <= rd_pend ? PL_DATA_i : '0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  id_q <= (cmd_op_i == OP_CHECK) ? '0 : cmd_id_i;
                  case (pl_op_e'(cmd_op_i))
                     OP_WRITE:  state <= ST_WRITE;
                     OP_READ:   state <= ST_READ;
                     OP_CHECK:  state <= ST_CHECK;
                     OP_STATUS: state <= ST_STATUS;
                  endcase
               end
            end
            ST_WRITE: begin
               if (wr_valid_i) begin
                  PL_ENA_o  <= 1'b1;
                  PL_WEN_o  <= 1'b1;
                  PL_DATA_o <= wr_data_i;
                  PL_ADDR_o <= beat_pl_addr;
                  if (beat_last) state <= ST_DRAIN;
               end
            end
            ST_CHECK: begin
               if (wr_valid_i) begin
                  PL_ENA_o  <= 1'b1;
                  PL_INIT_o <= 1'b1;
                  PL_REN_o  <= 1'b1;
                  PL_DATA_o <= wr_data_i;
                  PL_ADDR_o <= beat_pl_addr;
                  if (beat_last) state <= ST_DRAIN;
               end
            end
            ST_READ: begin
               PL_ENA_o  <= 1'b1;
               PL_REN_o  <= 1'b1;
               PL_ADDR_o <= beat_pl_addr;
               rd_pend   <= 1'b1;
               if (beat_last) state <= ST_DRAIN;
            end
            ST_STATUS: begin
               PL_ENA_o  <= 1'b1;
               PL_INIT_o <= 1'b1;
               PL_REN_o  <= 1'b1;
               PL_ADDR_o <= beat_pl_addr;
               rd_pend   <= 1'b1;
               state     <= ST_DRAIN;
            end
            ST_DRAIN: begin
               done_o <= 1'b1;
               state  <= ST_DONE;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

`ifdef PL_MASTER_ERR_EN
   // Sticky flag for a nonzero STATUS return (the only INIT beat with a read return)
   always_ff @(posedge PL_CLK_i or negedge RESET_ni) begin
      if (!RESET_ni) begin
         err_o <= 1'b0;
      end else if (accept) begin
         err_o <= 1'b0;
      end else if (rd_pend && PL_INIT_o && (PL_DATA_i != '0)) begin
         err_o <= 1'b1;
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: doc/pl_preload_master.md
PL_PRELOAD_MASTER -- requirements
Module: pl_preload_master

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning preload data width.
REQ-002 SHALL have parameter WADDR_W, default 10, meaning RAM word-address width (1024 words).
REQ-003 SHALL have port PL_CLK_i, input, 1 bit: preload clock; all state is on its rising edge.
REQ-004 SHALL have port RESET_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready_o, output, 1 bit: command accepted when high with cmd_valid_i.
REQ-007 SHALL have port cmd_op_i, input, 2 bits: operation; 0 WRITE, 1 READ, 2 CHECK, 3 STATUS.
REQ-008 SHALL have port cmd_id_i, input, 20 bits: target RAM {row[19:10], col[9:0]}; 0 selects broadcast.
REQ-009 SHALL have port cmd_addr_i, input, WADDR_W bits: start word address.
REQ-010 SHALL have port cmd_len_i, input, WADDR_W bits: beat count minus one.
REQ-011 SHALL have ports wr_valid_i (input, 1 bit), wr_ready_o (output, 1 bit) and wr_data_i (input, DATA_W bits): write or expected-data stream.
REQ-012 SHALL have ports rd_valid_o (output, 1 bit) and rd_data_o (output, DATA_W bits): read-return stream, no backpressure.
REQ-013 SHALL have outputs PL_ENA_o, PL_WEN_o, PL_REN_o and PL_INIT_o, each 1 bit: preload bus strobes.
REQ-014 SHALL have output PL_ADDR_o, 32 bits: {id[19:0], 2'b00, word address[9:0]}.
REQ-015 SHALL have output PL_DATA_o, DATA_W bits, which drives the chain PL_DATA_IN, and input PL_DATA_i, DATA_W bits, which is the chain PL_DATA_OUT.
REQ-016 SHALL have outputs busy_o, done_o (1-cycle pulse) and err_o (sticky), each 1 bit.

Function
REQ-017 SHALL implement the FSM IDLE -> {WRITE, READ, CHECK, STATUS} -> DRAIN -> DONE -> IDLE, and SHALL assert cmd_ready_o only in IDLE.
REQ-018 SHALL register all bus outputs; each bus beat SHALL be visible for exactly one PL_CLK_i cycle.
REQ-019 SHALL, in WRITE, assert wr_ready_o and issue one beat (PL_ENA_o=1, PL_WEN_o=1, PL_DATA_o=wr_data_i) per wr_valid_i&&wr_ready_o cycle; stall cycles SHALL drive ENA=WEN=0.
REQ-020 SHALL, in READ, issue one beat per cycle (PL_ENA_o=1, PL_REN_o=1), capture PL_DATA_i on the cycle after each beat, and present it on rd_data_o with rd_valid_o=1 (fixed 1-cycle latency).
REQ-021 SHALL, in CHECK, force id=0, assert PL_INIT_o=1 and PL_REN_o=1, drive PL_DATA_o=wr_data_i as the expected value, and gate each beat on the wr handshake.
REQ-022 SHALL, in STATUS, issue a single beat with PL_INIT_o=1 and PL_REN_o=1 to cmd_id_i, ignore cmd_len_i, and return one rd beat.
REQ-023 SHALL issue a beat count of cmd_len_i+1; cmd_len_i=1023 SHALL give 1024 beats.
REQ-024 SHALL increment the word address by 1 per issued beat, modulo 2^WADDR_W; 1023 SHALL wrap to 0.
REQ-025 SHALL use DRAIN for one cycle after the last beat to return the final READ/STATUS data, and SHALL enter DRAIN as a no-op for WRITE/CHECK.
REQ-026 SHALL pulse done_o for one cycle in DONE, and SHALL hold busy_o=1 in every state except IDLE.
REQ-027 SHALL latch the command fields on acceptance; input changes during an operation SHALL have no effect.

Reset
REQ-028 SHALL, on RESET_ni low, go to IDLE immediately and drive every output to 0 except cmd_ready_o=1 once RESET_ni is high.
REQ-029 SHALL, on reset mid-operation, abort the burst with no done_o and discard any pending read return.

Configuration
REQ-030 SHALL, with PL_MASTER_ERR_EN defined, set err_o when a STATUS return is nonzero, hold it until the next accepted command, and clear it on that command; without the macro, err_o SHALL be tied 0 and the compare logic SHALL be absent.

Structure
REQ-031 SHALL take the op enum, state enum and PL_ADDR field positions/widths from the shared package pl_master_pkg.
REQ-032 SHALL place the beat counter and address incrementer in one sub-module, pl_beat_gen (load, step, last).

Verification
REQ-033 SHALL cover: WRITE id=0x00401, addr=5, len=2, data 0x1,0x2,0x3 -> three beats at addresses 5,6,7 with PL_ADDR_o=0x00401005..7; done_o pulses once.
REQ-034 SHALL cover: READ addr=1022, len=3 -> beat addresses 1022,1023,0,1; four rd_valid_o pulses, each 1 cycle after its beat.
REQ-035 SHALL cover: WRITE with wr_valid_i toggling every other cycle -> ENA/WEN low on stall cycles; beat count exact.
REQ-036 SHALL cover: CHECK len=0, data 0x3FFFF -> one beat, PL_ADDR_o[31:12]=0, PL_INIT_o=1, PL_REN_o=1, PL_DATA_o=0x3FFFF.
REQ-037 SHALL cover: STATUS with PL_DATA_i=0x00010 -> rd_data_o=0x00010 and, with PL_MASTER_ERR_EN, err_o=1; the next command clears err_o.
REQ-038 SHALL cover: RESET_ni low during a READ beat 2 of 8 -> all outputs 0 the same cycle, no done_o, and IDLE after release.
